// File: rtl/apb_traffic_gen_if.sv
// rtl/apb_traffic_gen_if.sv - APB bus bundle between the traffic generator and a slave
interface apb_traffic_gen_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic              pwrite;
   logic              psel;
   logic              penable;
   logic              pready;
   logic [DATA_W-1:0] prdata;
   logic              pslverr;

   modport master (
      output paddr, pwdata, pwrite, psel, penable,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  paddr, pwdata, pwrite, psel, penable,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/apb_traffic_gen.sv
// rtl/apb_traffic_gen.sv - self-checking APB master issuing write/read-back pairs
module apb_traffic_gen #(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                NUM_TXN   = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                ADDR_STEP = 4,
   parameter logic [31:0]       SEED      = 32'hA5A50001,
   parameter int                TIMEOUT   = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   apb_traffic_gen_if.master     apb,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [15:0]           err_count,
   output logic                  timeout_err
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_W_SETUP  = 3'd1;
   localparam logic [2:0] S_W_ACCESS = 3'd2;
   localparam logic [2:0] S_R_SETUP  = 3'd3;
   localparam logic [2:0] S_R_ACCESS = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   localparam logic [31:0] PAT_STEP = 32'h01010101;
   localparam logic [31:0] LAST_IDX = 32'(NUM_TXN - 1);
   localparam logic [31:0] LAST_WAIT = 32'(TIMEOUT - 1);

   logic [2:0]        state;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       pat_q;
   logic [31:0]       idx_q;
   logic [31:0]       wait_q;
   logic [DATA_W-1:0] pat_d;

   logic              in_access;
   logic              beat_done;
   logic              wait_expired;
   logic              rd_mismatch;
   logic [1:0]        err_inc;
   logic [16:0]       err_sum;
   logic [15:0]       err_next;

   // Pattern word sized to the bus: truncated or zero-extended.
   assign pat_d = DATA_W'(pat_q);

   // Bus outputs decode straight from registered state, so a reset edge
   // drops psel/penable immediately and no half-finished transfer is seen.
   assign apb.psel    = (state == S_W_SETUP) || (state == S_W_ACCESS) ||
                        (state == S_R_SETUP) || (state == S_R_ACCESS);
   assign apb.penable = (state == S_W_ACCESS) || (state == S_R_ACCESS);
   assign apb.pwrite  = (state == S_W_SETUP) || (state == S_W_ACCESS);
   assign apb.paddr   = addr_q;
   assign apb.pwdata  = apb.pwrite ? pat_d : '0;

   assign busy = apb.psel;
   assign done = (state == S_DONE);
   assign pass = done && (err_count == 16'd0) && !timeout_err;

   assign in_access    = apb.penable;
   assign beat_done    = in_access && apb.pready;
   assign wait_expired = in_access && !apb.pready && (wait_q == LAST_WAIT);

   // Error contribution of the completing beat: slave error plus read miscompare.
   always_comb begin
      rd_mismatch = (state == S_R_ACCESS) && (apb.prdata != pat_d);
      err_inc     = {1'b0, beat_done && apb.pslverr} + {1'b0, beat_done && rd_mismatch};
      err_sum     = {1'b0, err_count} + 17'(err_inc);
      err_next    = err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end

   // Sequencer: SETUP -> ACCESS for the write, then the read-back, per pair.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         addr_q      <= '0;
         pat_q       <= '0;
         idx_q       <= '0;
         wait_q      <= '0;
         err_count   <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state       <= S_W_SETUP;
                  addr_q      <= BASE_ADDR;
                  pat_q       <= SEED;
                  idx_q       <= '0;
                  err_count   <= '0;
                  timeout_err <= 1'b0;
               end
            end
            S_W_SETUP: begin
               wait_q <= '0;
               state  <= S_W_ACCESS;
            end
            S_W_ACCESS: begin
               if (apb.pready) begin
                  err_count <= err_next;
                  state     <= S_R_SETUP;
               end else if (wait_expired) begin
                  timeout_err <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  wait_q <= wait_q + 32'd1;
               end
            end
            S_R_SETUP: begin
               wait_q <= '0;
               state  <= S_R_ACCESS;
            end
            S_R_ACCESS: begin
               if (apb.pready) begin
                  err_count <= err_next;
                  if (idx_q == LAST_IDX) begin
                     state <= S_DONE;
                  end else begin
                     idx_q  <= idx_q + 32'd1;
                     addr_q <= addr_q + ADDR_W'(ADDR_STEP);
                     pat_q  <= pat_q + PAT_STEP;
                     state  <= S_W_SETUP;
                  end
               end else if (wait_expired) begin
                  timeout_err <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  wait_q <= wait_q + 32'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_traffic_gen.sv
// tb/tb_apb_traffic_gen.sv - directed bench for apb_traffic_gen with a configurable memory slave
module tb_apb_traffic_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy, done, pass, timeout_err;
   logic [15:0] err_count;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   apb_traffic_gen_if #(.ADDR_W(32), .DATA_W(32)) apb ();

   apb_traffic_gen #(.NUM_TXN(4), .TIMEOUT(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .apb         (apb),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .err_count   (err_count),
      .timeout_err (timeout_err)
   );

   // Slave knobs set by the stimulus.
   int          wait_states = 0;
   bit          stuck       = 1'b0;
   bit          corrupt_en  = 1'b0;
   logic [31:0] corrupt_addr = '0;
   bit          slverr_en   = 1'b0;
   bit          slverr_wr   = 1'b0;
   logic [31:0] slverr_addr = '0;

   logic [31:0] mem [0:15];
   int          wcnt = 0;
   int          wn   = 0;
   logic [31:0] wlog_addr [0:15];
   logic [31:0] wlog_data [0:15];

   assign apb.pready  = apb.psel && apb.penable && !stuck && (wcnt >= wait_states);
   assign apb.prdata  = mem[apb.paddr[5:2]] ^
                        ((corrupt_en && apb.paddr == corrupt_addr) ? 32'h1 : 32'h0);
   assign apb.pslverr = apb.pready && slverr_en && (apb.paddr == slverr_addr) &&
                        (apb.pwrite == slverr_wr);

   // Memory slave with programmable wait states and a write log.
   always @(posedge clk) begin
      if (apb.psel && apb.penable) wcnt <= apb.pready ? 0 : wcnt + 1;
      else                         wcnt <= 0;
      if (apb.psel && apb.penable && apb.pready && apb.pwrite) begin
         mem[apb.paddr[5:2]] <= apb.pwdata;
         if (wn < 16) begin
            wlog_addr[wn] <= apb.paddr;
            wlog_data[wn] <= apb.pwdata;
         end
         wn <= wn + 1;
      end
   end

   // Bus-stability monitor across wait cycles.
   int          stab_err  = 0;
   int          wait_seen = 0;
   bit          prev_wait = 1'b0;
   logic [31:0] prev_addr, prev_wdata;
   logic        prev_write;
   always @(negedge clk) begin
      if (prev_wait) begin
         if (!(apb.psel && apb.penable) || apb.paddr !== prev_addr ||
             apb.pwdata !== prev_wdata || apb.pwrite !== prev_write)
            stab_err = stab_err + 1;
      end
      prev_wait  = apb.psel && apb.penable && !apb.pready;
      if (prev_wait) wait_seen = wait_seen + 1;
      prev_addr  = apb.paddr;
      prev_wdata = apb.pwdata;
      prev_write = apb.pwrite;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors = vectors + 1;
      assert (obs === exp) else begin
         miscompares = miscompares + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(inout int cyc);
      while (!done && cyc < 500) begin
         @(posedge clk); #1;
         cyc = cyc + 1;
      end
   endtask

   logic [31:0] exp_data [0:3];
   int cyc;

   initial begin
      exp_data[0] = 32'hA5A50001;
      exp_data[1] = 32'hA6A60102;
      exp_data[2] = 32'hA7A70203;
      exp_data[3] = 32'hA8A80304;
      for (int i = 0; i < 16; i++) mem[i] = '0;

      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl", {apb.psel, apb.penable, apb.pwrite, busy, done, pass, timeout_err, err_count}, '0);
      check("reset_bus", {apb.paddr, apb.pwdata}, '0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: zero-wait run
      pulse_start(); cyc = 0; wait_done(cyc);
      check("t1_latency", cyc, 16);
      check("t1_status", {done, pass, timeout_err, busy, apb.psel}, 5'b11000);
      check("t1_errs", err_count, 0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t1_waddr%0d", i), wlog_addr[i], 32'(4 * i));
         check($sformatf("t1_wdata%0d", i), wlog_data[i], exp_data[i]);
      end

      // 2: three wait states on every access
      wait_states = 3; stab_err = 0; wait_seen = 0;
      pulse_start(); cyc = 0; wait_done(cyc);
      check("t2_latency", cyc, 40);
      check("t2_pass", {done, pass}, 2'b11);
      check("t2_waits", wait_seen, 24);
      check("t2_stable", stab_err, 0);
      wait_states = 0;

      // 3: corrupted read-back of pair 2
      corrupt_en = 1'b1; corrupt_addr = 32'd8;
      pulse_start(); cyc = 0; wait_done(cyc);
      check("t3_latency", cyc, 16);
      check("t3_errs", err_count, 1);
      check("t3_status", {done, pass, timeout_err}, 3'b100);
      corrupt_en = 1'b0;

      // 4: stuck pready, timeout after 8 access cycles
      stuck = 1'b1;
      pulse_start(); cyc = 0; wait_done(cyc);
      check("t4_latency", cyc, 9);
      check("t4_status", {done, pass, timeout_err, busy, apb.psel, apb.penable}, 6'b101000);
      check("t4_errs", err_count, 0);
      stuck = 1'b0;

      // 5: slave error on write of pair 1
      slverr_en = 1'b1; slverr_wr = 1'b1; slverr_addr = 32'd4;
      pulse_start(); cyc = 0; wait_done(cyc);
      check("t5_latency", cyc, 16);
      check("t5_errs", err_count, 1);
      check("t5_status", {done, pass, timeout_err}, 3'b100);

      // 5b: slave error and miscompare on the same read beat
      slverr_wr = 1'b0; slverr_addr = 32'd12;
      corrupt_en = 1'b1; corrupt_addr = 32'd12;
      pulse_start(); cyc = 0; wait_done(cyc);
      check("t5b_latency", cyc, 16);
      check("t5b_errs", err_count, 2);
      slverr_en = 1'b0; corrupt_en = 1'b0;

      // 6a: start while busy is ignored
      pulse_start(); cyc = 0;
      repeat (5) begin @(posedge clk); #1; cyc = cyc + 1; end
      pulse_start(); cyc = cyc + 1;
      check("t6_ignored_bus", {busy, apb.pwrite, apb.paddr}, {2'b10, 32'd4});
      wait_done(cyc);
      check("t6_latency", cyc, 16);
      check("t6_pass", {done, pass}, 2'b11);

      // 6b: reset in the middle of pair 2
      pulse_start(); cyc = 0;
      repeat (9) begin @(posedge clk); #1; cyc = cyc + 1; end
      check("t6_pre_rst", {apb.psel, apb.penable, apb.pwrite, apb.paddr}, {3'b111, 32'd8});
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("t6_rst_ctrl", {apb.psel, apb.penable, apb.pwrite, busy, done, pass, timeout_err, err_count}, '0);
      check("t6_rst_bus", {apb.paddr, apb.pwdata}, '0);
      @(posedge clk); #1;
      pulse_start(); cyc = 0; wait_done(cyc);
      check("t6_clean_latency", cyc, 16);
      check("t6_clean_status", {done, pass, timeout_err}, 3'b110);
      check("t6_clean_errs", err_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
